// File: rtl/ex_branch_hazard_unit_pkg.sv
// Shared constants for the EX-stage ALU and ID-stage branch hazard logic.
//   WIDTH / REGW : default datapath and register-index widths
//   ALU_*        : 4-bit ALU operation codes
//   BR_*         : 3-bit branch type codes of the ID instruction
package ex_branch_hazard_unit_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned REGW  = 5;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_ADD  = 4'b1100;
  localparam logic [3:0] ALU_SUB  = 4'b1101;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLTZ = 3'b101;
  localparam logic [2:0] BR_BGEZ = 3'b110;

endpackage

// File: rtl/ex_branch_hazard_unit_alu_core.sv
// Purely combinational ALU.
//   alu_a   : operand A (A[4:0] is the shift amount for shifts)
//   alu_b   : operand B
//   alu_ctr : operation code (ALU_* in the package)
//   result  : operation result, wraps modulo 2^WIDTH
//   zero    : result == 0
//   ovf     : signed overflow, only for ADD/SUB
module ex_branch_hazard_unit_alu_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alu_ctr,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);
  import ex_branch_hazard_unit_pkg::*;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [4:0]       shamt;

  assign sum   = alu_a + alu_b;
  assign diff  = alu_a - alu_b;
  assign shamt = alu_a[4:0];

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_ctr)
      ALU_ADDU: result = sum;
      ALU_SUBU: result = diff;
      ALU_AND:  result = alu_a & alu_b;
      ALU_OR:   result = alu_a | alu_b;
      ALU_XOR:  result = alu_a ^ alu_b;
      ALU_NOR:  result = ~(alu_a | alu_b);
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
      ALU_SLL:  result = alu_b << shamt;
      ALU_SRL:  result = alu_b >> shamt;
      ALU_SRA:  result = $signed(alu_b) >>> shamt;
      ALU_LUI:  result = {alu_b[15:0], {(WIDTH-16){1'b0}}};
      ALU_ADD: begin
        result = sum;
        // Same-sign operands producing an opposite-sign sum.
        ovf    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = diff;
        // Opposite-sign operands where the difference takes B's sign.
        ovf    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_branch_hazard_unit.sv
// EX-stage ALU with EX/MEM result register, plus ID-stage branch operand
// forwarding (MEM -> ID) and branch bubble request.
//   clk, rst (sync, active-low)
//   alu_a/alu_b/alu_ctr -> alu_result/alu_zero/alu_ovf (comb), alu_result_q/alu_zero_q (reg)
//   id_ra/id_rb/id_branch, ex_regwr/ex_rw, mem_regwr/mem_memtoreg/mem_rw
//     -> branch_fwd_a/branch_fwd_b/branch_bubble (comb, independent of rst)
// Optional macro STALL_COUNTER_EN adds stall_count, counting bubble cycles.
module ex_branch_hazard_unit #(
  parameter int unsigned WIDTH = ex_branch_hazard_unit_pkg::WIDTH,
  parameter int unsigned REGW  = ex_branch_hazard_unit_pkg::REGW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alu_ctr,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_zero,
  output logic             alu_ovf,
  output logic [WIDTH-1:0] alu_result_q,
  output logic             alu_zero_q,
  input  logic [REGW-1:0]  id_ra,
  input  logic [REGW-1:0]  id_rb,
  input  logic [2:0]       id_branch,
  input  logic             ex_regwr,
  input  logic [REGW-1:0]  ex_rw,
  input  logic             mem_regwr,
  input  logic             mem_memtoreg,
  input  logic [REGW-1:0]  mem_rw,
  output logic             branch_fwd_a,
  output logic             branch_fwd_b,
  output logic             branch_bubble
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0]      stall_count
`endif
);
  import ex_branch_hazard_unit_pkg::*;

  ex_branch_hazard_unit_alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_ctr(alu_ctr),
    .result (alu_result),
    .zero   (alu_zero),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_result_q <= '0;
      alu_zero_q   <= 1'b0;
    end else begin
      alu_result_q <= alu_result;
      alu_zero_q   <= alu_zero;
    end
  end

  // A MEM ALU result can be forwarded; a MEM load cannot (data not yet read).
  logic mem_alu_wr;
  logic mem_load_wr;
  logic ex_wr;

  assign mem_alu_wr  = mem_regwr & ~mem_memtoreg & (mem_rw != '0);
  assign mem_load_wr = mem_regwr & mem_memtoreg & (mem_rw != '0);
  assign ex_wr       = ex_regwr & (ex_rw != '0);

  assign branch_fwd_a = mem_alu_wr & (mem_rw == id_ra);
  assign branch_fwd_b = mem_alu_wr & (mem_rw == id_rb);

  logic br_valid;
  logic use_rb;
  logic hit_a;
  logic hit_b;

  always_comb begin
    br_valid = 1'b0;
    use_rb   = 1'b0;
    case (id_branch)
      BR_BEQ, BR_BNE:                    begin br_valid = 1'b1; use_rb = 1'b1; end
      BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ: br_valid = 1'b1;
      default:                           br_valid = 1'b0;
    endcase
  end

  assign hit_a = (ex_wr & (ex_rw == id_ra)) | (mem_load_wr & (mem_rw == id_ra));
  assign hit_b = (ex_wr & (ex_rw == id_rb)) | (mem_load_wr & (mem_rw == id_rb));

  assign branch_bubble = br_valid & (hit_a | (use_rb & hit_b));

`ifdef STALL_COUNTER_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (branch_bubble) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_branch_hazard_unit.sv
module tb_ex_branch_hazard_unit;

  typedef struct {
    bit        rst;
    bit [31:0] a;
    bit [31:0] b;
    bit [3:0]  ctr;
    bit [4:0]  ra;
    bit [4:0]  rb;
    bit [2:0]  br;
    bit        exwr;
    bit [4:0]  exrw;
    bit        memwr;
    bit        memtoreg;
    bit [4:0]  memrw;
  } stim_t;

  typedef struct {
    bit [31:0] res;
    bit        zero;
    bit        ovf;
    bit [31:0] res_q;
    bit        zero_q;
    bit        fwd_a;
    bit        fwd_b;
    bit        bubble;
    bit [31:0] stall;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_result, alu_result_q;
  logic        alu_zero, alu_ovf, alu_zero_q;
  logic [4:0]  id_ra, id_rb, ex_rw, mem_rw;
  logic [2:0]  id_branch;
  logic        ex_regwr, mem_regwr, mem_memtoreg;
  logic        branch_fwd_a, branch_fwd_b, branch_bubble;
`ifdef STALL_COUNTER_EN
  logic [31:0] stall_count;
`endif

  ex_branch_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctr      (alu_ctr),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_ovf      (alu_ovf),
    .alu_result_q (alu_result_q),
    .alu_zero_q   (alu_zero_q),
    .id_ra        (id_ra),
    .id_rb        (id_rb),
    .id_branch    (id_branch),
    .ex_regwr     (ex_regwr),
    .ex_rw        (ex_rw),
    .mem_regwr    (mem_regwr),
    .mem_memtoreg (mem_memtoreg),
    .mem_rw       (mem_rw),
    .branch_fwd_a (branch_fwd_a),
    .branch_fwd_b (branch_fwd_b),
    .branch_bubble(branch_bubble)
`ifdef STALL_COUNTER_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Model state carried across clock edges.
  bit        prev_rst = 1'b0;
  bit [31:0] prev_res = 32'd0;
  bit        prev_zero = 1'b0;
  bit        prev_bubble = 1'b0;
  bit [31:0] stall_model = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the operation table, using wide signed arithmetic.
  function automatic void ref_alu(input stim_t s, output bit [31:0] res, output bit ovf);
    longint sa = longint'($signed(s.a));
    longint sb = longint'($signed(s.b));
    longint wide;
    int     sbi = int'(s.b);
    int     sh = int'(s.a % 32);
    res = 32'd0;
    ovf = 1'b0;
    case (s.ctr)
      4'd0:  res = s.a + s.b;
      4'd1:  res = s.a - s.b;
      4'd2:  res = s.a & s.b;
      4'd3:  res = s.a | s.b;
      4'd4:  res = s.a ^ s.b;
      4'd5:  res = ~(s.a | s.b);
      4'd6:  res = (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  res = (s.a < s.b) ? 32'd1 : 32'd0;
      4'd8:  res = s.b << sh;
      4'd9:  res = s.b >> sh;
      4'd10: res = 32'(sbi >>> sh);
      4'd11: res = (s.b % 32'h10000) * 32'h10000;
      4'd12, 4'd13: begin
        wide = (s.ctr == 4'd12) ? sa + sb : sa - sb;
        res  = 32'(wide);
        ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      default: res = 32'd0;
    endcase
  endfunction

  function automatic bit ref_bubble(input stim_t s);
    bit [4:0] used[$];
    if (s.br == 3'd0 || s.br == 3'd7) return 1'b0;
    used.push_back(s.ra);
    if (s.br == 3'd1 || s.br == 3'd2) used.push_back(s.rb);
    foreach (used[i]) begin
      if (used[i] != 5'd0) begin
        if (s.exwr && s.exrw == used[i]) return 1'b1;
        if (s.memwr && s.memtoreg && s.memrw == used[i]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit ref_fwd(input stim_t s, input bit [4:0] r);
    return s.memwr && !s.memtoreg && s.memrw != 5'd0 && s.memrw == r;
  endfunction

  task automatic drive(input stim_t s);
    alu_a = s.a; alu_b = s.b; alu_ctr = s.ctr;
    id_ra = s.ra; id_rb = s.rb; id_branch = s.br;
    ex_regwr = s.exwr; ex_rw = s.exrw;
    mem_regwr = s.memwr; mem_memtoreg = s.memtoreg; mem_rw = s.memrw;
    rst = s.rst;
  endtask

  // Advance one edge, apply the stimulus and queue what the DUT should show.
  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    if (!prev_rst) stall_model = 32'd0;
    else if (prev_bubble) stall_model = stall_model + 32'd1;
    e.res_q  = prev_rst ? prev_res : 32'd0;
    e.zero_q = prev_rst ? prev_zero : 1'b0;
    e.stall  = stall_model;
    drive(s);
    ref_alu(s, e.res, e.ovf);
    e.zero   = (e.res == 32'd0);
    e.fwd_a  = ref_fwd(s, s.ra);
    e.fwd_b  = ref_fwd(s, s.rb);
    e.bubble = ref_bubble(s);
    sb_q.push_back(e);
    prev_rst    = s.rst;
    prev_res    = e.res;
    prev_zero   = e.zero;
    prev_bubble = e.bubble;
  endtask

  function automatic stim_t mk(bit r, bit [31:0] a, bit [31:0] b, bit [3:0] c, bit [4:0] ra,
                               bit [4:0] rb, bit [2:0] br, bit exwr, bit [4:0] exrw,
                               bit memwr, bit memtoreg, bit [4:0] memrw);
    stim_t s;
    s.rst = r; s.a = a; s.b = b; s.ctr = c; s.ra = ra; s.rb = rb; s.br = br;
    s.exwr = exwr; s.exrw = exrw; s.memwr = memwr; s.memtoreg = memtoreg; s.memrw = memrw;
    return s;
  endfunction

  // Monitor: compare every queued expectation away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("alu_result",   alu_result,    e.res);
        check("alu_zero",     32'(alu_zero), 32'(e.zero));
        check("alu_ovf",      32'(alu_ovf),  32'(e.ovf));
        check("alu_result_q", alu_result_q,  e.res_q);
        check("alu_zero_q",   32'(alu_zero_q), 32'(e.zero_q));
        check("branch_fwd_a", 32'(branch_fwd_a), 32'(e.fwd_a));
        check("branch_fwd_b", 32'(branch_fwd_b), 32'(e.fwd_b));
        check("branch_bubble", 32'(branch_bubble), 32'(e.bubble));
`ifdef STALL_COUNTER_EN
        check("stall_count",  stall_count, e.stall);
`endif
      end
    end
  end

  stim_t dir[$];

  initial begin
    stim_t s;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 32'h5, 32'h3, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    dir.push_back(mk(1, 32'h7FFFFFFF, 32'hFFFFFFFF, 4'd13, 0, 0, 0, 0, 0, 0, 0, 0));
    dir.push_back(mk(1, 32'h0, 32'h0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    dir.push_back(mk(1, 32'hFFFFFFFF, 32'h1, 4'd6, 0, 0, 0, 0, 0, 0, 0, 0));
    dir.push_back(mk(1, 32'hFFFFFFFF, 32'h1, 4'd7, 0, 0, 0, 0, 0, 0, 0, 0));
    dir.push_back(mk(1, 32'h4, 32'h80000000, 4'd10, 0, 0, 0, 0, 0, 0, 0, 0));
    dir.push_back(mk(1, 32'h0, 32'h1234, 4'd11, 0, 0, 0, 0, 0, 0, 0, 0));
    dir.push_back(mk(1, 32'h7FFFFFFF, 32'h1, 4'd12, 5, 6, 1, 1, 6, 0, 0, 0));
    dir.push_back(mk(1, 32'h1, 32'h1, 4'd1, 5, 6, 1, 1, 0, 0, 0, 0));
    dir.push_back(mk(1, 32'h24, 32'hF0, 4'd8, 5, 6, 3, 1, 6, 0, 0, 0));
    dir.push_back(mk(1, 32'h3, 32'h80000000, 4'd9, 8, 1, 2, 0, 0, 1, 0, 8));
    dir.push_back(mk(1, 32'hA, 32'h5, 4'd5, 8, 1, 2, 0, 0, 1, 1, 8));
    dir.push_back(mk(1, 32'hA, 32'h5, 4'd4, 3, 4, 0, 1, 3, 0, 0, 0));
    dir.push_back(mk(1, 32'hA, 32'h5, 4'd14, 0, 0, 4, 0, 0, 1, 0, 0));
    dir.push_back(mk(1, 32'h9, 32'h9, 4'd2, 7, 9, 1, 1, 9, 1, 0, 9));
    dir.push_back(mk(0, 32'h9, 32'h9, 4'd3, 2, 0, 1, 1, 2, 0, 0, 0));
    dir.push_back(mk(1, 32'h1, 32'h2, 4'd0, 2, 0, 1, 1, 2, 0, 0, 0));
    dir.push_back(mk(1, 32'h1, 32'h2, 4'd0, 2, 0, 1, 1, 2, 0, 0, 0));
    dir.push_back(mk(1, 32'h1, 32'h2, 4'd0, 2, 0, 1, 1, 2, 0, 0, 0));
    dir.push_back(mk(1, 32'h1, 32'h2, 4'd15, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (dir[i]) apply(dir[i]);

    for (int n = 0; n < 400; n++) begin
      s.rst      = ($urandom_range(0, 15) != 0);
      s.a        = $urandom();
      s.b        = $urandom();
      if ($urandom_range(0, 3) == 0) s.a = {$urandom_range(0, 1) == 1, 31'($urandom())};
      if ($urandom_range(0, 5) == 0) s.b = s.a;
      s.ctr      = 4'($urandom_range(0, 15));
      s.ra       = 5'($urandom_range(0, 7));
      s.rb       = 5'($urandom_range(0, 7));
      s.br       = 3'($urandom_range(0, 7));
      s.exwr     = 1'($urandom_range(0, 1));
      s.exrw     = 5'($urandom_range(0, 7));
      s.memwr    = 1'($urandom_range(0, 1));
      s.memtoreg = 1'($urandom_range(0, 1));
      s.memrw    = 5'($urandom_range(0, 7));
      apply(s);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
